clock_gate_ctrl: RTL
====================

// Module: clock_gate_ctrl
// PURPOSE
//  Multi-channel clock gating controller. Successor to the single active-low-latch clock gate.
//  - NUM_CH independent, glitch-free latch-based gates, one per channel.
//  - Per-channel idle-timeout auto-gating, software on/off, and a timed wake sequence with a ready flag.
//  - Global test override.
//  - Sits at the top level between the core clock and per-unit clock domains (FPU, MUL/DIV, AMO unit).
// PARAMETERS
//  NUM_CH       4   number of gated channels (>=1)
//  IDLE_CYCLES  16  consecutive idle cycles before auto-gating (>=1)
//  WAKE_CYCLES  2   cycles of running clock after ungating before ready asserts (>=0)
// PORTS
//  clock         in   1       free-running core clock
//  reset         in   1       synchronous, active-high reset
//  test_enable   in   1       1 = all gated clocks forced running; FSM state unaffected
//  sw_on         in   NUM_CH  software permission to run channel i (0 = gate)
//  auto_gate_en  in   NUM_CH  1 = channel i may auto-gate when idle
//  activity      in   NUM_CH  channel i has work pending (driven from ungated logic)
//  gated_clock   out  NUM_CH  gated clock for channel i
//  ready         out  NUM_CH  channel i clock running and settled
//  gated_status  out  NUM_CH  channel i is in GATED state
// BEHAVIOUR
//  Reset (sampled on the clock rising edge while reset=1):
//   - All channels go to RUN; idle_cnt=0, wake_cnt=0, clk_en=1.
//   - ready=all 1, gated_status=0; gated_clock follows clock.
//   - Reset overrides all other inputs. Reset in any state, including mid-WAKE, returns the channel to RUN.
//  Per-channel FSM (registered, rising edge):
//   RUN (clk_en=1, ready=1):
//    - sw_on=0 -> GATED.
//    - Else auto_gate_en=1 and activity=0: idle_cnt++. idle_cnt==IDLE_CYCLES-1 with activity still 0 -> GATED, idle_cnt=0.
//    - activity=1 or auto_gate_en=0 -> idle_cnt=0.
//   GATED (clk_en=0, ready=0, gated_status=1):
//    - sw_on=1 and (activity=1 or auto_gate_en=0) -> WAKE, wake_cnt=0.
//    - If WAKE_CYCLES==0, go directly to RUN instead.
//   WAKE (clk_en=1, ready=0):
//    - sw_on=0 -> GATED.
//    - Else wake_cnt++. wake_cnt==WAKE_CYCLES-1 -> RUN.
//   - Illegal state encoding -> RUN.
//  Counters:
//   - idle_cnt width $clog2(IDLE_CYCLES+1); saturates, never wraps.
//   - wake_cnt width $clog2(WAKE_CYCLES+1), min 1.
//  Gate cell, per channel:
//   - en_eff = clk_en | test_enable.
//   - Latch is transparent while clock=0; gated_clock = latch_q & clock.
//   - clk_en changes just after a rising edge. The change takes effect at the NEXT rising edge, with no runt pulses.
//  Latencies:
//   - Transition into GATED at edge k -> the first suppressed gated_clock pulse is edge k+1.
//   - GATED->WAKE at edge k -> the first gated_clock pulse is at edge k+1, and ready rises WAKE_CYCLES edges after edge k.
//  Simultaneous events:
//   - sw_on=0 has priority over activity in every state.
//   - test_enable never alters state, counters or ready.
//   - Channels are fully independent; there is no cross-channel interaction.
// TESTING
//  1. IDLE_CYCLES=4, sw_on=1, auto=1, activity falls at edge 0:
//     gated_status=1 after edge 3; no gated_clock pulse from edge 4 on.
//  2. Same as 1, but an activity pulse at edge 2:
//     idle_cnt clears; gating occurs at edge 6, not edge 3.
//  3. WAKE_CYCLES=2, channel GATED, activity=1 at edge k:
//     gated_clock pulse at edge k+1; ready=1 after edge k+2.
//  4. Channel GATED, test_enable=1 for 5 cycles:
//     gated_clock toggles 5 times; gated_status stays 1; ready stays 0.
//  5. reset=1 mid-WAKE:
//     next edge gives ready=1, gated_status=0, clock running. Also: sw_on=0 in RUN with activity=1 -> GATED next edge.
//  6. Random clk_en/test_enable toggling, NUM_CH=4:
//     every gated_clock high pulse has exactly the clock high width (glitch checker).

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock gating controller: per-channel latch-based glitch-free gate,
// idle-timeout auto-gating, software on/off, and timed wake sequence with ready flag.
module clock_gate_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              test_enable,
   input  logic [NUM_CH-1:0] sw_on,
   input  logic [NUM_CH-1:0] auto_gate_en,
   input  logic [NUM_CH-1:0] activity,
   output logic [NUM_CH-1:0] gated_clock,
   output logic [NUM_CH-1:0] ready,
   output logic [NUM_CH-1:0] gated_status
);

   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam int WW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
   localparam logic [WW-1:0] WAKE_LAST = (WAKE_CYCLES > 0) ? WW'(WAKE_CYCLES - 1) : WW'(0);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_GATED = 2'b01,
      ST_WAKE  = 2'b10
   } state_t;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      state_t        state_r;
      logic [IW-1:0] idle_cnt_r;
      logic [WW-1:0] wake_cnt_r;
      logic          clk_en_r;
      logic          ready_r;
      logic          gated_r;
      logic          en_eff_s;
      logic          latch_q;

      // Channel state machine with registered clk_en/ready/gated flags
      always_ff @(posedge clock) begin
         if (reset) begin
            state_r    <= ST_RUN;
            idle_cnt_r <= '0;
            wake_cnt_r <= '0;
            clk_en_r   <= 1'b1;
            ready_r    <= 1'b1;
            gated_r    <= 1'b0;
         end else begin
            case (state_r)
               ST_RUN: begin
                  wake_cnt_r <= '0;
                  if (!sw_on[ch]) begin
                     state_r    <= ST_GATED;
                     idle_cnt_r <= '0;
                     clk_en_r   <= 1'b0;
                     ready_r    <= 1'b0;
                     gated_r    <= 1'b1;
                  end else if (auto_gate_en[ch] && !activity[ch]) begin
                     if (idle_cnt_r == IDLE_LAST) begin
                        state_r    <= ST_GATED;
                        idle_cnt_r <= '0;
                        clk_en_r   <= 1'b0;
                        ready_r    <= 1'b0;
                        gated_r    <= 1'b1;
                     end else if (idle_cnt_r != IDLE_MAX) begin
                        idle_cnt_r <= idle_cnt_r + IW'(1);
                     end else begin
                        idle_cnt_r <= idle_cnt_r;
                     end
                  end else begin
                     idle_cnt_r <= '0;
                  end
               end
               ST_GATED: begin
                  idle_cnt_r <= '0;
                  wake_cnt_r <= '0;
                  if (sw_on[ch] && (activity[ch] || !auto_gate_en[ch])) begin
                     clk_en_r <= 1'b1;
                     gated_r  <= 1'b0;
                     if (WAKE_CYCLES == 0) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                     end else begin
                        state_r <= ST_WAKE;
                        ready_r <= 1'b0;
                     end
                  end else begin
                     state_r <= ST_GATED;
                  end
               end
               ST_WAKE: begin
                  idle_cnt_r <= '0;
                  if (!sw_on[ch]) begin
                     state_r    <= ST_GATED;
                     wake_cnt_r <= '0;
                     clk_en_r   <= 1'b0;
                     ready_r    <= 1'b0;
                     gated_r    <= 1'b1;
                  end else if (wake_cnt_r == WAKE_LAST) begin
                     state_r    <= ST_RUN;
                     wake_cnt_r <= '0;
                     ready_r    <= 1'b1;
                  end else begin
                     wake_cnt_r <= wake_cnt_r + WW'(1);
                  end
               end
               default: begin
                  state_r    <= ST_RUN;
                  idle_cnt_r <= '0;
                  wake_cnt_r <= '0;
                  clk_en_r   <= 1'b1;
                  ready_r    <= 1'b1;
                  gated_r    <= 1'b0;
               end
            endcase
         end
      end

      assign en_eff_s = clk_en_r | test_enable;

      // Transparent-low latch: enable changes reach the gated clock only at the next rising edge
      always_latch begin
         if (!clock) begin
            latch_q <= en_eff_s;
         end
      end

      assign gated_clock[ch]  = latch_q & clock;
      assign ready[ch]        = ready_r;
      assign gated_status[ch] = gated_r;
   end

endmodule
